// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding and default geometry for the pong game controller
package pong_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } game_state_t;

   localparam int DEF_CLKS_PER_MOVE = 250_000;
   localparam int DEF_ACTIVE_ROWS   = 480;
   localparam int DEF_ACTIVE_COLS   = 640;
   localparam int DEF_SIDE_LEN      = 16;
   localparam int DEF_PADDLE_H      = 64;
   localparam int DEF_PADDLE_X      = 16;
   localparam int DEF_WIN_SCORE     = 7;
   localparam int DEF_SERVE_MOVES   = 120;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// rtl/pong_game_ctrl_if.sv - position inputs, ball strobes and score outputs of the game controller
interface pong_game_ctrl_if import pong_pkg::*; #(
   parameter int ACTIVE_COLS = DEF_ACTIVE_COLS,
   parameter int ACTIVE_ROWS = DEF_ACTIVE_ROWS,
   parameter int WIN_SCORE   = DEF_WIN_SCORE
);
   logic                             start;
   logic [$clog2(ACTIVE_COLS)-1:0]   ball_x;
   logic [$clog2(ACTIVE_ROWS)-1:0]   ball_y;
   logic [$clog2(ACTIVE_ROWS)-1:0]   paddle_l_y;
   logic [$clog2(ACTIVE_ROWS)-1:0]   paddle_r_y;
   logic                             move_tick;
   logic                             ball_load;
   logic                             serve_dir;
   logic                             flip_x;
   logic                             flip_y;
   logic [$clog2(WIN_SCORE+1)-1:0]   score_l;
   logic [$clog2(WIN_SCORE+1)-1:0]   score_r;
   logic                             game_over;
   logic                             winner;

   modport master (
      input  start, ball_x, ball_y, paddle_l_y, paddle_r_y,
      output move_tick, ball_load, serve_dir, flip_x, flip_y,
             score_l, score_r, game_over, winner
   );

   modport slave (
      output start, ball_x, ball_y, paddle_l_y, paddle_r_y,
      input  move_tick, ball_load, serve_dir, flip_x, flip_y,
             score_l, score_r, game_over, winner
   );
endinterface

// File: rtl/move_tick_gen.sv
// rtl/move_tick_gen.sv - free-running move timebase, tick high on the counter wrap cycle
module move_tick_gen #(
   parameter int CLKS_PER_MOVE = 250_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int             CW     = $clog2(CLKS_PER_MOVE + 1);
   localparam logic [CW-1:0]  C_LAST = CW'(CLKS_PER_MOVE - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_tick = (r_cnt == C_LAST);
endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - serve/play/point/over sequencer with collision detection and scoring
module pong_game_ctrl import pong_pkg::*; #(
   parameter int CLKS_PER_MOVE = DEF_CLKS_PER_MOVE,
   parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
   parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
   parameter int SIDE_LEN      = DEF_SIDE_LEN,
   parameter int PADDLE_H      = DEF_PADDLE_H,
   parameter int PADDLE_X      = DEF_PADDLE_X,
   parameter int WIN_SCORE     = DEF_WIN_SCORE,
   parameter int SERVE_MOVES   = DEF_SERVE_MOVES
) (
   input  logic               clk,
   input  logic               rst_n,
   pong_game_ctrl_if.master   bus
);
   localparam int XW = $clog2(ACTIVE_COLS);
   localparam int YW = $clog2(ACTIVE_ROWS);
   localparam int SW = $clog2(WIN_SCORE + 1);
   localparam int DW = $clog2(SERVE_MOVES + 1);

   // One extra bit on geometry so position+size sums never wrap
   localparam logic [XW:0]   C_MISS_R  = (XW+1)'(ACTIVE_COLS - SIDE_LEN);
   localparam logic [XW:0]   C_PAD_L   = (XW+1)'(PADDLE_X);
   localparam logic [XW:0]   C_PAD_R   = (XW+1)'(ACTIVE_COLS - PADDLE_X);
   localparam logic [XW:0]   C_SIDE_X  = (XW+1)'(SIDE_LEN);
   localparam logic [YW:0]   C_SIDE_Y  = (YW+1)'(SIDE_LEN);
   localparam logic [YW:0]   C_PAD_H   = (YW+1)'(PADDLE_H);
   localparam logic [YW:0]   C_WALL_B  = (YW+1)'(ACTIVE_ROWS - SIDE_LEN);
   localparam logic [SW-1:0] C_WIN     = SW'(WIN_SCORE);
   localparam logic [DW-1:0] C_DLY_END = DW'(SERVE_MOVES - 1);

   game_state_t   r_state;
   logic          r_start_q;
   logic [DW-1:0] r_delay;
   logic [SW-1:0] r_score_l, r_score_r;
   logic          r_move_tick, r_ball_load, r_serve_dir, r_flip_x, r_flip_y;
   logic          r_game_over, r_winner;

   logic          w_tick, w_start_rise, w_delay_done;
   logic [XW:0]   w_bx;
   logic [YW:0]   w_by, w_pl, w_pr;
   logic          w_overlap_l, w_overlap_r, w_hit_l, w_hit_r, w_wall, w_miss_l, w_miss_r;
   logic [SW-1:0] w_score_l_inc, w_score_r_inc;

   move_tick_gen #(.CLKS_PER_MOVE(CLKS_PER_MOVE)) u_move_tick_gen (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .o_tick  (w_tick)
   );

   assign w_start_rise = bus.start & ~r_start_q;
   assign w_delay_done = (r_delay == C_DLY_END);

   assign w_bx = {1'b0, bus.ball_x};
   assign w_by = {1'b0, bus.ball_y};
   assign w_pl = {1'b0, bus.paddle_l_y};
   assign w_pr = {1'b0, bus.paddle_r_y};

   assign w_overlap_l = (w_by + C_SIDE_Y > w_pl) && (w_by < w_pl + C_PAD_H);
   assign w_overlap_r = (w_by + C_SIDE_Y > w_pr) && (w_by < w_pr + C_PAD_H);
   assign w_hit_l     = (w_bx == C_PAD_L) && w_overlap_l;
   assign w_hit_r     = (w_bx + C_SIDE_X == C_PAD_R) && w_overlap_r;
   assign w_wall      = (w_by == '0) || (w_by == C_WALL_B);
   assign w_miss_l    = (w_bx == '0);
   assign w_miss_r    = (w_bx == C_MISS_R);

   assign w_score_l_inc = (r_score_l == C_WIN) ? r_score_l : r_score_l + SW'(1);
   assign w_score_r_inc = (r_score_r == C_WIN) ? r_score_r : r_score_r + SW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_start_q   <= 1'b0;
         r_delay     <= '0;
         r_score_l   <= '0;
         r_score_r   <= '0;
         r_move_tick <= 1'b0;
         r_ball_load <= 1'b0;
         r_serve_dir <= 1'b1;
         r_flip_x    <= 1'b0;
         r_flip_y    <= 1'b0;
         r_game_over <= 1'b0;
         r_winner    <= 1'b0;
      end else begin
         r_start_q   <= bus.start;
         r_move_tick <= 1'b0;
         r_ball_load <= 1'b0;
         r_flip_x    <= 1'b0;
         r_flip_y    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_rise) begin
                  r_state     <= SERVE;
                  r_ball_load <= 1'b1;
               end
            end
            SERVE: begin
               if (w_tick) begin
                  if (w_delay_done) begin
                     r_delay <= '0;
                     r_state <= PLAY;
                  end else begin
                     r_delay <= r_delay + DW'(1);
                  end
               end
            end
            PLAY: begin
               // A miss suppresses the step and every flip on that tick
               if (w_tick) begin
                  if (w_miss_l) begin
                     r_score_r   <= w_score_r_inc;
                     r_serve_dir <= 1'b0;
                     r_state     <= POINT;
                  end else if (w_miss_r) begin
                     r_score_l   <= w_score_l_inc;
                     r_serve_dir <= 1'b1;
                     r_state     <= POINT;
                  end else begin
                     r_move_tick <= 1'b1;
                     r_flip_x    <= w_hit_l | w_hit_r;
                     r_flip_y    <= w_wall;
                  end
               end
            end
            POINT: begin
               if (w_tick) begin
                  if (w_delay_done) begin
                     r_delay <= '0;
                     if ((r_score_l == C_WIN) || (r_score_r == C_WIN)) begin
                        r_state     <= OVER;
                        r_game_over <= 1'b1;
                        r_winner    <= (r_score_r == C_WIN);
                     end else begin
                        r_state     <= SERVE;
                        r_ball_load <= 1'b1;
                     end
                  end else begin
                     r_delay <= r_delay + DW'(1);
                  end
               end
            end
            OVER: begin
               if (w_start_rise) begin
                  r_score_l   <= '0;
                  r_score_r   <= '0;
                  r_serve_dir <= 1'b1;
                  r_game_over <= 1'b0;
                  r_winner    <= 1'b0;
                  r_ball_load <= 1'b1;
                  r_state     <= SERVE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.move_tick = r_move_tick;
   assign bus.ball_load = r_ball_load;
   assign bus.serve_dir = r_serve_dir;
   assign bus.flip_x    = r_flip_x;
   assign bus.flip_y    = r_flip_y;
   assign bus.score_l   = r_score_l;
   assign bus.score_r   = r_score_r;
   assign bus.game_over = r_game_over;
   assign bus.winner    = r_winner;
endmodule
